// File: rtl/credit_sender_if.sv
// Push/pop link bundle for the credit sender: upstream valid/ready push channel plus
// the credit-guaranteed pop channel and reset-sync handshake toward the receiver.
interface credit_sender_if #(
  parameter int unsigned WIDTH = 8
);
  logic             push_valid;
  logic             push_ready;
  logic [WIDTH-1:0] push_data;
  logic             pop_sender_in_reset;
  logic             pop_receiver_in_reset;
  logic             pop_credit;
  logic             pop_valid;
  logic [WIDTH-1:0] pop_data;

  // Environment side: produces pushes, plays the receiver.
  modport master (
    output push_valid, push_data, pop_receiver_in_reset, pop_credit,
    input  push_ready, pop_sender_in_reset, pop_valid, pop_data
  );

  // Credit sender side.
  modport slave (
    input  push_valid, push_data, pop_receiver_in_reset, pop_credit,
    output push_ready, pop_sender_in_reset, pop_valid, pop_data
  );
endinterface

// File: rtl/credit_sender.sv
// Sender end of a credit-based flow-control link with reset-sync handshake.
// Optional CREDIT_SENDER_POP_REG_EN adds a one-cycle flop stage on the pop channel.
module credit_sender #(
  parameter  int unsigned WIDTH      = 8,
  parameter  int unsigned MAX_CREDIT = 15,
  localparam int unsigned CW         = $clog2(MAX_CREDIT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  credit_sender_if.slave link,
  input  logic [CW-1:0] credit_initial,
  input  logic [CW-1:0] credit_withhold,
  output logic [CW-1:0] credit_count,
  output logic [CW-1:0] credit_available,
  output logic          credit_overflow
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] count_nxt;
  logic          overflow_nxt;
  logic          send;

  // Spendable credits after the withheld amount, floored at zero.
  assign credit_available = (credit_count > credit_withhold) ?
                            CW'(credit_count - credit_withhold) : '0;

  assign link.push_ready          = (state == ST_ACTIVE) && (credit_available != '0);
  assign link.pop_sender_in_reset = (state == ST_RESET);
  assign send                     = link.push_valid && link.push_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= ST_RESET;
      credit_count    <= '0;
      credit_overflow <= 1'b0;
    end else begin
      state           <= state_nxt;
      credit_count    <= count_nxt;
      credit_overflow <= overflow_nxt;
    end
  end

  // Next-state and credit accounting; credits are reloaded while not linked.
  always_comb begin
    state_nxt    = state;
    count_nxt    = credit_count;
    overflow_nxt = credit_overflow;
    unique case (state)
      ST_RESET: begin
        state_nxt = ST_SYNC;
        count_nxt = credit_initial;
      end
      ST_SYNC: begin
        count_nxt = credit_initial;
        if (!link.pop_receiver_in_reset) begin
          state_nxt = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        if (link.pop_receiver_in_reset) begin
          state_nxt = ST_SYNC;
        end
        if (send && !link.pop_credit) begin
          count_nxt = CW'(credit_count - CW'(1));
        end else if (!send && link.pop_credit) begin
          if (credit_count == CW'(MAX_CREDIT)) begin
            overflow_nxt = 1'b1;
          end else begin
            count_nxt = CW'(credit_count + CW'(1));
          end
        end
      end
      default: begin
        state_nxt = ST_RESET;
      end
    endcase
  end

`ifdef CREDIT_SENDER_POP_REG_EN
  logic             pop_valid_q;
  logic [WIDTH-1:0] pop_data_q;

  // Credit was already spent at acceptance; this stage only delays the beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      pop_valid_q <= (state == ST_ACTIVE) && send;
      if (send) begin
        pop_data_q <= WIDTH'(link.push_data);
      end
    end
  end

  assign link.pop_valid = pop_valid_q;
  assign link.pop_data  = pop_data_q;
`else
  assign link.pop_valid = send;
  assign link.pop_data  = WIDTH'(link.push_data);
`endif

endmodule

// File: tb/tb_credit_sender.sv
// Self-checking bench for credit_sender: directed test-plan steps followed by random traffic
// against an arithmetic reference model of the credit rules.
module tb_credit_sender;
  localparam int unsigned WIDTH      = 8;
  localparam int unsigned MAX_CREDIT = 15;
  localparam int unsigned CW         = 4;
`ifdef CREDIT_SENDER_POP_REG_EN
  localparam bit POP_REG = 1'b1;
`else
  localparam bit POP_REG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [CW-1:0] credit_initial;
  logic [CW-1:0] credit_withhold;
  logic [CW-1:0] credit_count;
  logic [CW-1:0] credit_available;
  logic          credit_overflow;

  always #5 clk = ~clk;

  credit_sender_if #(.WIDTH(WIDTH)) lnk ();

  credit_sender #(.WIDTH(WIDTH), .MAX_CREDIT(MAX_CREDIT)) dut (
    .clk              (clk),
    .rst              (rst),
    .link             (lnk),
    .credit_initial   (credit_initial),
    .credit_withhold  (credit_withhold),
    .credit_count     (credit_count),
    .credit_available (credit_available),
    .credit_overflow  (credit_overflow)
  );

  // Reference model: link phase (0 sender in reset, 1 waiting on receiver, 2 linked).
  int m_phase;
  int m_count;
  bit m_ovf;
  bit m_pend_v;
  int m_pend_d;

  int n_pass   = 0;
  int n_checks = 0;
  int n_pops   = 0;
  int q_obs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check combinational outputs, clock, update model, check state.
  task automatic tick(input bit v, input int d, input bit cr);
    int avail;
    int nxt;
    bit rdy;
    bit snd;
    bit exp_pv;
    int exp_pd;
    lnk.push_valid = v;
    lnk.push_data  = WIDTH'(d);
    lnk.pop_credit = cr;
    #1;
    avail = (m_count > int'(credit_withhold)) ? m_count - int'(credit_withhold) : 0;
    rdy   = (m_phase == 2) && (avail > 0);
    snd   = v && rdy;
    if (POP_REG) begin
      exp_pv = m_pend_v;
      exp_pd = m_pend_d;
    end else begin
      exp_pv = snd;
      exp_pd = d & 255;
    end
    chk("credit_available", 32'(credit_available), 32'(avail));
    chk("push_ready", 32'(lnk.push_ready), 32'(rdy));
    chk("pop_valid", 32'(lnk.pop_valid), 32'(exp_pv));
    if (exp_pv) chk("pop_data", 32'(lnk.pop_data), 32'(exp_pd));
    if (lnk.pop_valid === 1'b1) begin
      n_pops++;
      q_obs.push_back(int'(lnk.pop_data));
    end
    @(posedge clk);
    m_pend_v = snd;
    if (snd) m_pend_d = d & 255;
    case (m_phase)
      0: begin
        m_count = int'(credit_initial);
        m_phase = 1;
      end
      1: begin
        m_count = int'(credit_initial);
        if (!lnk.pop_receiver_in_reset) m_phase = 2;
      end
      default: begin
        nxt = m_count - int'(snd) + int'(cr);
        if (nxt > int'(MAX_CREDIT)) begin
          nxt   = int'(MAX_CREDIT);
          m_ovf = 1'b1;
        end
        m_count = nxt;
        if (lnk.pop_receiver_in_reset) m_phase = 1;
      end
    endcase
    #1;
    chk("credit_count", 32'(credit_count), 32'(m_count));
    chk("credit_overflow", 32'(credit_overflow), 32'(m_ovf));
    chk("pop_sender_in_reset", 32'(lnk.pop_sender_in_reset), 32'(m_phase == 0));
  endtask

  // Assert rst (possibly mid-transfer), hold it n cycles, release away from the edge.
  task automatic do_reset(input int n);
    rst      = 1'b0;
    m_phase  = 0;
    m_count  = 0;
    m_ovf    = 1'b0;
    m_pend_v = 1'b0;
    #1;
    chk("rst_pop_valid", 32'(lnk.pop_valid), 32'(0));
    chk("rst_push_ready", 32'(lnk.push_ready), 32'(0));
    chk("rst_credit_count", 32'(credit_count), 32'(0));
    chk("rst_credit_overflow", 32'(credit_overflow), 32'(0));
    chk("rst_sender_in_reset", 32'(lnk.pop_sender_in_reset), 32'(1));
    lnk.push_valid = 1'b0;
    lnk.pop_credit = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    chk("rst_hold_sender_in_reset", 32'(lnk.pop_sender_in_reset), 32'(1));
    chk("rst_hold_push_ready", 32'(lnk.push_ready), 32'(0));
    rst = 1'b1;
  endtask

  initial begin
    rst                       = 1'b0;
    lnk.push_valid            = 1'b0;
    lnk.push_data             = '0;
    lnk.pop_credit            = 1'b0;
    lnk.pop_receiver_in_reset = 1'b1;
    credit_initial            = 4'd4;
    credit_withhold           = 4'd0;
    m_pend_d                  = 0;

    // Reset and sync with receiver held in reset.
    do_reset(3);
    repeat (4) tick(1'b1, 8'h01, 1'b1);
    chk("sync_count_loaded", 32'(credit_count), 32'(4));
    lnk.pop_receiver_in_reset = 1'b0;
    tick(1'b0, 0, 1'b0);

    // Exhaust four credits with six offered beats.
    n_pops = 0;
    q_obs.delete();
    for (int i = 0; i < 6; i++) tick(1'b1, 'h10 + i, 1'b0);
    tick(1'b0, 0, 1'b0);
    chk("exhaust_pops", 32'(n_pops), 32'(4));
    for (int i = 0; i < 4; i++)
      chk("exhaust_data", (i < q_obs.size()) ? 32'(q_obs[i]) : 32'hdead, 32'('h10 + i));
    chk("exhaust_count", 32'(credit_count), 32'(0));

    // Simultaneous send and credit return leave the count unchanged.
    repeat (2) tick(1'b0, 0, 1'b1);
    n_pops = 0;
    for (int i = 0; i < 5; i++) tick(1'b1, 'h20 + i, 1'b1);
    tick(1'b0, 0, 1'b0);
    chk("simul_count", 32'(credit_count), 32'(2));
    chk("simul_pops", 32'(n_pops), 32'(5));
    tick(1'b0, 0, 1'b1);
    chk("simul_credit_only", 32'(credit_count), 32'(3));

    // Withhold blocks traffic, then allows exactly two sends.
    repeat (2) tick(1'b0, 0, 1'b1);
    credit_withhold = 4'd5;
    tick(1'b1, 'h30, 1'b0);
    credit_withhold = 4'd3;
    n_pops = 0;
    for (int i = 0; i < 4; i++) tick(1'b1, 'h31 + i, 1'b0);
    tick(1'b0, 0, 1'b0);
    chk("withhold_pops", 32'(n_pops), 32'(2));
    chk("withhold_count", 32'(credit_count), 32'(3));
    credit_withhold = 4'd9;
    repeat (2) tick(1'b1, 'h38, 1'b1);
    chk("withhold_high_count", 32'(credit_count), 32'(5));
    credit_withhold = 4'd0;

    // Receiver reset pulse reloads credits and ignores returns.
    for (int g = 0; g < 20 && m_count > 1; g++) tick(1'b1, 'h40 + g, 1'b0);
    chk("rxrst_pre_count", 32'(credit_count), 32'(1));
    lnk.pop_receiver_in_reset = 1'b1;
    repeat (2) tick(1'b0, 0, 1'b1);
    lnk.pop_receiver_in_reset = 1'b0;
    tick(1'b0, 0, 1'b1);
    chk("rxrst_reload", 32'(credit_count), 32'(4));

    // Overflow saturates and is sticky until rst.
    for (int g = 0; g < 20 && m_count < int'(MAX_CREDIT); g++) tick(1'b0, 0, 1'b1);
    tick(1'b0, 0, 1'b1);
    chk("ovf_count", 32'(credit_count), 32'(MAX_CREDIT));
    chk("ovf_flag", 32'(credit_overflow), 32'(1));
    tick(1'b1, 'hA5, 1'b0);
    tick(1'b0, 0, 1'b0);
    chk("ovf_sticky", 32'(credit_overflow), 32'(1));
    lnk.push_valid = 1'b1;
    do_reset(2);
    repeat (2) tick(1'b0, 0, 1'b0);

    // Randomized traffic with withhold changes, receiver pulses and mid-transfer resets.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) credit_withhold = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 39) == 0) lnk.pop_receiver_in_reset = 1'b1;
      else if ($urandom_range(0, 2) == 0) lnk.pop_receiver_in_reset = 1'b0;
      if ($urandom_range(0, 149) == 0) begin
        lnk.push_valid = 1'b1;
        credit_initial = CW'($urandom_range(1, 8));
        do_reset(1);
      end
      tick(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
